servo_pwm_5bits: RTL and testbench
==================================

# servo_pwm_5bits

Servo pulse generator that consumes the 5-bit position word selected by the upstream 5-bit 2:1 position multiplexer and drives the servo control line. It produces a fixed-period PWM frame whose high time is a linear function of the position. The position is latched once per frame, so a change at the multiplexer output (select toggling, operand change) never alters a pulse already in progress.

## Interface
- PRESCALE, 500: clock cycles per tick; 10 µs at 50 MHz. Must be ≥ 1.
- PERIOD_TICKS, 2000: ticks per frame; 20 ms. Must be ≤ 65535.
- MIN_TICKS, 100: pulse width for POS = 0; 1.0 ms. Must be ≥ 1.
- STEP_TICKS, 3: additional ticks per POS LSB. MIN_TICKS + 31·STEP_TICKS must be < PERIOD_TICKS.
- CLK  input  1  system clock; all state changes on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- EN  input  1  frame generation enable.
- POS  input  5  position command, unsigned 0..31; driven by the upstream mux OUT.
- PWM  output  1  servo control pulse; registered.
- PERIOD_START  output  1  one-cycle strobe marking the first cycle of each frame; registered.
- ACTIVE_POS  output  5  position latched for the current frame; registered.

## Operation
- Reset (RST_N = 0) takes effect immediately, with no clock required.
  - Reset values: PWM = 0, PERIOD_START = 0, ACTIVE_POS = 0, all internal counters = 0.
  - Block is in IDLE state.
- States:
  - IDLE: outputs low, counters held at 0.
  - RUN: a frame is in progress.
- IDLE → RUN on the first rising edge with RST_N = 1 and EN = 1. That edge is the frame edge.
- Frame edge actions:
  - POS is sampled into ACTIVE_POS.
  - PERIOD_START = 1 for exactly one cycle.
  - PWM = 1.
  - Prescale counter and tick counter restart at 0.
- Pulse width W = MIN_TICKS + ACTIVE_POS·STEP_TICKS ticks.
  - Compute in 16 bits unsigned, no overflow by parameter constraint.
  - PWM stays high for exactly W·PRESCALE clock cycles, then goes low.
- Frame length is exactly PERIOD_TICKS·PRESCALE clock cycles. The edge ending the frame is the next frame edge: POS is re-sampled and PERIOD_START and PWM are asserted.
- POS changes between frame edges have no effect until the next frame edge.
- RUN → IDLE on the first edge with EN = 0.
  - PWM = 0 and PERIOD_START = 0 at that edge.
  - Counters are cleared.
  - ACTIVE_POS retains its value.
- Re-asserting EN starts a fresh full frame on the first edge with EN = 1. A partial frame is never resumed.
- Prescaler wrap: counts 0..PRESCALE-1. A tick is the cycle in which it equals PRESCALE-1.
- Tick counter wrap: counts 0..PERIOD_TICKS-1. It wraps coincident with the frame edge.

## Timing
- Latency from POS to pulse width: POS is applied at the next frame edge. Worst case is one full frame (PERIOD_TICKS·PRESCALE cycles).
- PERIOD_START is high in the same cycle in which PWM first reads 1 for that frame.
- PWM has no glitches: it is a flop output and changes only at the frame edge and at the W·PRESCALE boundary.
- A pulse never reaches the frame end, because W < PERIOD_TICKS. PWM is therefore low in the last cycle of every frame.
- If RST_N is asserted mid-pulse, PWM falls asynchronously. After release, behaviour is identical to power-up.
- If EN falls and RST_N is asserted in the same cycle, reset dominates.

## Test plan
Parameters for all scenarios unless stated: PRESCALE = 2, PERIOD_TICKS = 100, MIN_TICKS = 4, STEP_TICKS = 2. Frame length = 200 cycles.

- **Reset values:** hold RST_N = 0 with EN = 1, POS = 17 → PWM = 0, PERIOD_START = 0, ACTIVE_POS = 0. Drop RST_N mid-cycle with no clock → outputs go to 0 immediately.
- **Minimum position:** POS = 0, EN = 1 → PERIOD_START one cycle wide every 200 cycles, PWM high 8 cycles per frame, ACTIVE_POS = 0.
- **Maximum position:** POS = 31 → PWM high 132 cycles and low 68 cycles per frame, ACTIVE_POS = 31.
- **Mid-frame position change:** POS = 0, then change POS to 31 at cycle 50 of the frame → current frame PWM high 8 cycles; next frame PWM high 132 cycles, with ACTIVE_POS = 31 from that frame edge.
- **Enable drop:** POS = 10, giving W = 24 ticks = 48 cycles. Drop EN at cycle 20 of the frame → PWM = 0 at the next edge. Re-raise EN 37 cycles later → PERIOD_START and PWM = 1 on the first edge with EN = 1, then a full 48-cycle pulse.
- **Reset mid-pulse:** POS = 31, assert RST_N = 0 at cycle 60 of the frame → PWM = 0 asynchronously. Release RST_N with EN = 1 → a new frame starts on the first edge, with PWM high 132 cycles.

Source files
------------

// File: rtl/servo_pwm_5bits.sv
// Servo PWM frame generator: latches a 5-bit position once per frame and
// drives a pulse of MIN_TICKS + pos*STEP_TICKS ticks in a fixed frame.
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           frame generation enable
//   pos          position command 0..31 (from upstream mux)
//   pwm          registered servo pulse
//   period_start registered one-cycle strobe on first cycle of each frame
//   active_pos   registered position latched for the current frame
module servo_pwm_5bits #(
   parameter int PRESCALE     = 500,
   parameter int PERIOD_TICKS = 2000,
   parameter int MIN_TICKS    = 100,
   parameter int STEP_TICKS   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [4:0] pos,
   output logic       pwm,
   output logic       period_start,
   output logic [4:0] active_pos
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [15:0]   tick_q, tick_d;
   logic          pwm_d;
   logic          ps_d;
   logic [4:0]    apos_d;

   logic          tick;
   logic          frame_end;
   logic          pulse_end;
   logic [15:0]   width;

   // Width follows the latched position, so pos changes mid-frame are inert.
   assign width     = 16'(MIN_TICKS) + 16'(active_pos) * 16'(STEP_TICKS);
   assign tick      = (pre_q == PW'(PRESCALE - 1));
   assign frame_end = tick && (tick_q == 16'(PERIOD_TICKS - 1));
   assign pulse_end = tick && (tick_q == width - 16'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pre_q        <= '0;
         tick_q       <= '0;
         pwm          <= 1'b0;
         period_start <= 1'b0;
         active_pos   <= '0;
      end else begin
         state_q      <= state_d;
         pre_q        <= pre_d;
         tick_q       <= tick_d;
         pwm          <= pwm_d;
         period_start <= ps_d;
         active_pos   <= apos_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      tick_d  = tick_q;
      pwm_d   = pwm;
      ps_d    = 1'b0;
      apos_d  = active_pos;
      unique case (state_q)
         IDLE: begin
            pre_d  = '0;
            tick_d = '0;
            pwm_d  = 1'b0;
            if (en) begin
               state_d = RUN;
               apos_d  = pos;
               ps_d    = 1'b1;
               pwm_d   = 1'b1;
            end
         end
         RUN: begin
            if (!en) begin
               // Abandon the frame; a fresh one starts on re-enable.
               state_d = IDLE;
               pre_d   = '0;
               tick_d  = '0;
               pwm_d   = 1'b0;
            end else if (frame_end) begin
               // Frame boundary doubles as the next frame edge.
               pre_d  = '0;
               tick_d = '0;
               apos_d = pos;
               ps_d   = 1'b1;
               pwm_d  = 1'b1;
            end else begin
               if (tick) begin
                  pre_d  = '0;
                  tick_d = tick_q + 16'd1;
               end else begin
                  pre_d  = pre_q + PW'(1);
               end
               if (pulse_end) begin
                  pwm_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_servo_pwm_5bits.sv
// Directed bench for servo_pwm_5bits with a 200-cycle frame
// (PRESCALE=2, PERIOD_TICKS=100, MIN_TICKS=4, STEP_TICKS=2).
module tb_servo_pwm_5bits;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [4:0] pos;
   logic       pwm;
   logic       period_start;
   logic [4:0] active_pos;

   int checks = 0;
   int errors = 0;

   servo_pwm_5bits #(
      .PRESCALE    (2),
      .PERIOD_TICKS(100),
      .MIN_TICKS   (4),
      .STEP_TICKS  (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .pos         (pos),
      .pwm         (pwm),
      .period_start(period_start),
      .active_pos  (active_pos)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at the negedge of cycle 0 of a frame; returns at cycle 0 of
   // the following frame.
   task automatic run_frame(input int chg_at, input logic [4:0] chg_val,
                            output int hi, output int fall,
                            output int psn, output int last,
                            output int ap_end);
      hi = 0; fall = 200; psn = 0; last = 0; ap_end = 0;
      for (int i = 0; i < 200; i++) begin
         if (i == chg_at) pos = chg_val;
         hi  += int'(pwm);
         psn += int'(period_start);
         if (!pwm && fall == 200) fall = i;
         if (i == 199) begin
            last   = int'(pwm);
            ap_end = int'(active_pos);
         end
         @(negedge clk);
      end
   endtask

   int hi, fall, psn, last, ap_end, cnt;

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      pos   = 5'd17;
      repeat (3) @(negedge clk);
      check("rst_pwm", int'(pwm), 0);
      check("rst_ps", int'(period_start), 0);
      check("rst_ap", int'(active_pos), 0);

      // Release: first edge is a frame edge
      pos   = 5'd0;
      rst_n = 1'b1;
      @(negedge clk);
      check("start_ps", int'(period_start), 1);
      check("start_pwm", int'(pwm), 1);
      check("start_ap", int'(active_pos), 0);

      // Minimum position, W=4 ticks -> 8 cycles
      run_frame(-1, 5'd0, hi, fall, psn, last, ap_end);
      check("min_fall", fall, 8);
      check("min_hi", hi, 8);
      check("min_psn", psn, 1);
      check("min_last", last, 0);
      check("min_next_ps", int'(period_start), 1);

      // Change to 31 at cycle 50: no effect in this frame
      run_frame(50, 5'd31, hi, fall, psn, last, ap_end);
      check("chg_fall", fall, 8);
      check("chg_hi", hi, 8);
      check("chg_ap_end", ap_end, 0);

      // Next frame picks up 31: W=66 -> 132 high, 68 low
      check("max_ap", int'(active_pos), 31);
      run_frame(-1, 5'd0, hi, fall, psn, last, ap_end);
      check("max_fall", fall, 132);
      check("max_hi", hi, 132);
      check("max_lo", 200 - hi, 68);
      check("max_last", last, 0);

      // Steady max frame, switch to 10 late for the next frame
      run_frame(150, 5'd10, hi, fall, psn, last, ap_end);
      check("max2_hi", hi, 132);
      check("max2_psn", psn, 1);

      // Enable drop at cycle 20 of a W=24 (48-cycle) frame
      check("en_ap", int'(active_pos), 10);
      check("en_ps", int'(period_start), 1);
      repeat (20) @(negedge clk);
      check("en_c20_pwm", int'(pwm), 1);
      en = 1'b0;
      cnt = 0;
      for (int k = 0; k < 37; k++) begin
         @(negedge clk);
         if (k == 0) begin
            check("en_off_pwm", int'(pwm), 0);
            check("en_off_ps", int'(period_start), 0);
            check("en_off_ap", int'(active_pos), 10);
         end
         cnt += int'(pwm) + int'(period_start);
      end
      check("en_off_quiet", cnt, 0);
      en = 1'b1;
      @(negedge clk);
      check("en_on_ps", int'(period_start), 1);
      check("en_on_pwm", int'(pwm), 1);
      run_frame(100, 5'd31, hi, fall, psn, last, ap_end);
      check("en_fall", fall, 48);
      check("en_hi", hi, 48);

      // Reset mid-pulse at cycle 60 of a 132-cycle pulse
      check("rp_ap", int'(active_pos), 31);
      repeat (60) @(negedge clk);
      check("rp_c60_pwm", int'(pwm), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rp_async_pwm", int'(pwm), 0);
      check("rp_async_ps", int'(period_start), 0);
      check("rp_async_ap", int'(active_pos), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rp_ps", int'(period_start), 1);
      check("rp_ap2", int'(active_pos), 31);
      run_frame(-1, 5'd0, hi, fall, psn, last, ap_end);
      check("rp_fall", fall, 132);
      check("rp_hi", hi, 132);
      check("rp_psn", psn, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
